// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mvm_pkg
//  Purpose  : Shared types and sizing helpers for the matrix-vector multiplier
//             and its streaming front end.
//  Contents : mvm_state_t   - front-end sequencing states
//             mvm_total()   - element count of one load (N*N matrix + N vector)
//             mvm_cnt_w()   - counter width able to hold 0..v-1 (min 1 bit)
//             c_mvm_*       - default-configuration counts and widths
//  Revision : 1.0 - initial release
// ============================================================================
package mvm_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        DRAIN   = 2'd3
    } mvm_state_t;

    function automatic int mvm_total(input int n);
        return n * n + n;
    endfunction

    function automatic int mvm_cnt_w(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    // Default configuration (N=3, TIMEOUT=64)
    localparam int c_mvm_n           = 3;
    localparam int c_mvm_timeout     = 64;
    localparam int c_mvm_total       = mvm_total(c_mvm_n);
    localparam int c_mvm_elem_cnt_w  = mvm_cnt_w(c_mvm_total);
    localparam int c_mvm_out_cnt_w   = mvm_cnt_w(c_mvm_n);
    localparam int c_mvm_wait_cnt_w  = mvm_cnt_w(c_mvm_timeout + 1);

endpackage
`default_nettype wire

// File: rtl/matvec_result_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : matvec_result_serializer
//  Purpose  : Holds one captured N-element result vector and emits it element
//             by element on a valid/ready stream, element 0 first.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             load            - capture load_data and start streaming
//             load_data       - packed result vector, element j at [j*WIDTH]
//             m_valid/m_ready - output stream handshake
//             m_data          - current element
//             m_last          - current element is element N-1
//  Revision : 1.0 - initial release
// ============================================================================
module matvec_result_serializer
    import mvm_pkg::*;
#(
    parameter int N     = 3,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [N*WIDTH-1:0]   load_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_last
);

    localparam int                c_idx_w    = mvm_cnt_w(N);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N - 1);

    logic [N*WIDTH-1:0] r_data;
    logic [c_idx_w-1:0] r_idx;
    logic               r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= load_data;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (r_valid && m_ready) begin
            if (r_idx == c_last_idx) begin
                r_valid <= 1'b0;
                r_idx   <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Data and last are pure functions of registers, so they stay put while
    // the consumer stalls.
    assign m_valid = r_valid;
    assign m_data  = r_data[r_idx*WIDTH +: WIDTH];
    assign m_last  = r_valid && (r_idx == c_last_idx);

endmodule
`default_nettype wire

// File: rtl/matvec_stream_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : matvec_stream_frontend
//  Purpose  : Packs a serial stream of N*N matrix elements (row-major) then N
//             vector elements into the multiplier operand buses, pulses the
//             multiplier start, waits for done (bounded by TIMEOUT) and
//             streams the N result elements back out.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             s_valid/s_ready/s_data   - input element stream
//             m_valid/m_ready/m_data/m_last - result element stream
//             mvm_ena                  - one-cycle multiplier start
//             mvm_matrix_a/mvm_vector_b - packed operands to the multiplier
//             mvm_vector_c/mvm_done    - packed result and completion pulse
//             busy                     - a computation is in flight
//             timeout_err              - sticky: last run timed out
//  Revision : 1.0 - initial release
// ============================================================================
module matvec_stream_frontend
    import mvm_pkg::*;
#(
    parameter int N       = 3,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data,
    output logic                   m_last,
    output logic                   mvm_ena,
    output logic [N*N*WIDTH-1:0]   mvm_matrix_a,
    output logic [N*WIDTH-1:0]     mvm_vector_b,
    input  logic [N*WIDTH-1:0]     mvm_vector_c,
    input  logic                   mvm_done,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int                 c_total    = mvm_total(N);
    localparam int                 c_elem_w   = mvm_cnt_w(c_total);
    localparam int                 c_wait_w   = mvm_cnt_w(TIMEOUT + 1);
    localparam logic [c_elem_w-1:0] c_nn_idx   = c_elem_w'(N * N);
    localparam logic [c_elem_w-1:0] c_last_idx = c_elem_w'(c_total - 1);
    localparam logic [c_wait_w-1:0] c_wait_end = c_wait_w'(TIMEOUT - 1);

    mvm_state_t              r_state;
    logic [c_elem_w-1:0]     r_elem_idx;
    logic [c_wait_w-1:0]     r_wait_cnt;
    logic [N*N*WIDTH-1:0]    r_mat;
    logic [N*WIDTH-1:0]      r_vec;
    logic                    r_ena;
    logic                    r_terr;

    logic                    w_s_hs;
    logic                    w_load;
    logic                    w_drain_done;

    assign s_ready      = (r_state == COLLECT) && !rst;
    assign w_s_hs       = s_valid && s_ready;
    // Done is only meaningful while waiting; a stray pulse elsewhere is dropped.
    assign w_load       = (r_state == WAIT) && mvm_done;
    assign w_drain_done = m_valid && m_ready && m_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= COLLECT;
            r_elem_idx <= '0;
            r_wait_cnt <= '0;
            r_mat      <= '0;
            r_vec      <= '0;
            r_ena      <= 1'b0;
            r_terr     <= 1'b0;
        end else begin
            r_ena <= 1'b0;
            case (r_state)
                COLLECT: begin
                    if (w_s_hs) begin
                        if (r_elem_idx < c_nn_idx) begin
                            r_mat[r_elem_idx*WIDTH +: WIDTH] <= s_data;
                        end else begin
                            r_vec[(r_elem_idx - c_nn_idx)*WIDTH +: WIDTH] <= s_data;
                        end
                        if (r_elem_idx == c_last_idx) begin
                            r_elem_idx <= '0;
                            r_state    <= START;
                            // Registered so the pulse lines up with START.
                            r_ena      <= 1'b1;
                            r_terr     <= 1'b0;
                        end else begin
                            r_elem_idx <= r_elem_idx + 1'b1;
                        end
                    end
                end
                START: begin
                    r_wait_cnt <= '0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    // Done is tested first so it wins over a same-cycle timeout.
                    if (mvm_done) begin
                        r_state <= DRAIN;
                    end else if (r_wait_cnt == c_wait_end) begin
                        r_terr  <= 1'b1;
                        r_state <= COLLECT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= COLLECT;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    matvec_result_serializer #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .load_data (mvm_vector_c),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    assign mvm_ena      = r_ena;
    assign mvm_matrix_a = r_mat;
    assign mvm_vector_b = r_vec;
    assign busy         = (r_state != COLLECT);
    assign timeout_err  = r_terr;

endmodule
`default_nettype wire

// File: tb/tb_matvec_stream_frontend.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_matvec_stream_frontend
//  Purpose  : Self-checking bench for matvec_stream_frontend with a behavioural
//             multiplier stub and a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matvec_stream_frontend;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int TO = 64;
    localparam int NE = N * N + N;

    typedef logic [7:0] elems_t [NE];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic          mvm_ena;
    logic [71:0]   mvm_matrix_a;
    logic [23:0]   mvm_vector_b;
    logic [23:0]   mvm_vector_c = '0;
    logic          mvm_done = 1'b0;
    logic          busy;
    logic          timeout_err;

    always #5 clk = ~clk;

    matvec_stream_frontend #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .mvm_ena      (mvm_ena),
        .mvm_matrix_a (mvm_matrix_a),
        .mvm_vector_b (mvm_vector_b),
        .mvm_vector_c (mvm_vector_c),
        .mvm_done     (mvm_done),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  got[$];
    int          ena_count = 0;
    int          stub_lat = 2;      // -1: never completes
    int          mready_mode = 1;   // 0 low, 1 high, 2 random

    function automatic void chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk8(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chkw(string name, logic [71:0] act, logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chki(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Row r of A times b, truncated to the element width.
    function automatic logic [7:0] dot_row(logic [71:0] a, logic [23:0] b, int r);
        int s;
        s = 0;
        for (int j = 0; j < N; j++)
            s += int'($signed(a[(r*N+j)*8 +: 8])) * int'($signed(b[j*8 +: 8]));
        return s[7:0];
    endfunction

    // ---------------- multiplier stub ----------------
    initial begin : stub
        bit          armed;
        bit          counting;
        int          k;
        logic [23:0] c;
        armed = 0; counting = 0; k = 0; c = '0;
        forever begin
            @(posedge clk); #2;
            mvm_done     = 1'b0;
            mvm_vector_c = 24'($urandom());
            if (rst) begin
                armed = 0; counting = 0;
            end else if (counting) begin
                if (k == 0) begin
                    mvm_done = 1'b1; mvm_vector_c = c; counting = 0;
                end else k--;
            end else if (armed) begin
                for (int r = 0; r < N; r++) c[r*8 +: 8] = dot_row(mvm_matrix_a, mvm_vector_b, r);
                armed = 0;
                if (stub_lat >= 0) begin counting = 1; k = stub_lat; end
            end
            if (!rst && mvm_ena) armed = 1;
        end
    end

    // ---------------- m_ready driver ----------------
    initial begin : mready_drv
        forever begin
            @(posedge clk); #1;
            case (mready_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- reference model + compare ----------------
    bit          m_rst_prev = 0;
    int          m_nin = 0;
    logic [7:0]  m_cur [NE];
    logic [71:0] m_exp_a = '0;
    logic [23:0] m_exp_b = '0;
    logic [7:0]  m_pend [N];
    logic [7:0]  m_res  [N];
    bit          m_ena_due = 0, m_in_wait = 0, m_mv_due = 0, m_drain = 0;
    bit          m_to_due = 0, m_terr = 0;
    int          m_wcnt = 0, m_oidx = 0;

    always @(negedge clk) begin : compare
        bit ena_now;
        if (m_rst_prev) begin
            chk1("rst_m_valid", m_valid, 1'b0);
            chk8("rst_m_data", m_data, 8'h00);
            chk1("rst_m_last", m_last, 1'b0);
            chk1("rst_mvm_ena", mvm_ena, 1'b0);
            chkw("rst_matrix_a", mvm_matrix_a, 72'h0);
            chkw("rst_vector_b", 72'(mvm_vector_b), 72'h0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_timeout_err", timeout_err, 1'b0);
        end
        if (rst) begin
            chk1("s_ready_in_rst", s_ready, 1'b0);
            m_rst_prev = 1; m_nin = 0; m_ena_due = 0; m_in_wait = 0; m_mv_due = 0;
            m_drain = 0; m_to_due = 0; m_terr = 0; m_wcnt = 0; m_oidx = 0;
        end else begin
            m_rst_prev = 0;
            if (m_to_due) begin m_terr = 1; m_to_due = 0; end
            ena_now = m_ena_due;
            chk1("mvm_ena", mvm_ena, ena_now);
            if (mvm_ena) ena_count++;
            if (ena_now) begin
                m_terr = 0;
                chkw("matrix_a", mvm_matrix_a, m_exp_a);
                chkw("vector_b", 72'(mvm_vector_b), 72'(m_exp_b));
                m_ena_due = 0;
            end
            chk1("timeout_err", timeout_err, m_terr);
            if (m_mv_due) begin m_drain = 1; m_oidx = 0; m_mv_due = 0; end
            chk1("m_valid", m_valid, m_drain);
            chk1("busy", busy, ena_now || m_in_wait || m_drain);
            chk1("s_ready", s_ready, !(ena_now || m_in_wait || m_drain));
            if (m_drain) begin
                chk8("m_data", m_data, m_res[m_oidx]);
                chk1("m_last", m_last, m_oidx == N - 1);
                if (m_ready) begin
                    got.push_back(m_data);
                    m_oidx++;
                    if (m_oidx == N) m_drain = 0;
                end
            end
            if (m_in_wait) begin
                m_wcnt++;
                if (mvm_done) begin
                    m_res = m_pend; m_mv_due = 1; m_in_wait = 0;
                end else if (m_wcnt == TO) begin
                    m_to_due = 1; m_in_wait = 0;
                end
            end
            if (ena_now) begin m_in_wait = 1; m_wcnt = 0; end
            if (s_valid && s_ready) begin
                m_cur[m_nin] = s_data;
                m_nin++;
                if (m_nin == NE) begin
                    for (int e = 0; e < N * N; e++) m_exp_a[e*8 +: 8] = m_cur[e];
                    for (int e = 0; e < N; e++)     m_exp_b[e*8 +: 8] = m_cur[N*N+e];
                    for (int r = 0; r < N; r++)     m_pend[r] = dot_row(m_exp_a, m_exp_b, r);
                    m_ena_due = 1;
                    m_nin = 0;
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send(input elems_t v, input bit gaps, input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            bit hs;
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            s_valid = 1'b1;
            s_data  = v[i];
            guard = 0; hs = 0;
            while (!hs && guard < 300) begin
                @(negedge clk); hs = s_ready;
                @(posedge clk); #1;
                guard++;
            end
            s_valid = 1'b0;
            s_data  = 8'($urandom());
            if (!hs) begin
                errors++; checks++;
                $display("FAIL send_timeout: element %0d not accepted", i);
                return;
            end
        end
    endtask

    task automatic wait_out(input int n);
        int guard;
        guard = 0;
        while (got.size() < n && guard < 400) begin @(negedge clk); guard++; end
        chki("out_count", got.size(), n);
        @(posedge clk); #1;
    endtask

    task automatic wait_timeout();
        int guard;
        guard = 0;
        while (!timeout_err && guard < 200) begin @(negedge clk); guard++; end
        chk1("timeout_reached", timeout_err, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int cyc);
        rst = 1'b1;
        repeat (cyc) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        chk8({name, "_0"}, got[0], e0);
        chk8({name, "_1"}, got[1], e1);
        chk8({name, "_2"}, got[2], e2);
    endtask

    elems_t v;
    int     e0;

    initial begin : main
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("s_ready_after_rst", s_ready, 1'b1);
        @(posedge clk); #1;

        // Identity matrix, vector {1,2,3}
        got.delete(); e0 = ena_count;
        v = '{8'd1,8'd0,8'd0, 8'd0,8'd1,8'd0, 8'd0,8'd0,8'd1, 8'd1,8'd2,8'd3};
        send(v, 0, NE); wait_out(3);
        chk_out("identity", 8'd1, 8'd2, 8'd3);
        chki("identity_ena_pulses", ena_count - e0, 1);

        // All 2s times ones, then all 1s back-to-back
        got.delete();
        v = '{8'd2,8'd2,8'd2, 8'd2,8'd2,8'd2, 8'd2,8'd2,8'd2, 8'd1,8'd1,8'd1};
        send(v, 0, NE); wait_out(3);
        chk_out("twos", 8'd6, 8'd6, 8'd6);
        got.delete();
        v = '{8'd1,8'd1,8'd1, 8'd1,8'd1,8'd1, 8'd1,8'd1,8'd1, 8'd1,8'd1,8'd1};
        send(v, 0, NE); wait_out(3);
        chk_out("ones", 8'd3, 8'd3, 8'd3);

        // Negative element
        got.delete();
        v = '{8'hFF,8'd0,8'd0, 8'd0,8'd0,8'd0, 8'd0,8'd0,8'd0, 8'd5,8'd7,8'd9};
        send(v, 0, NE); wait_out(3);
        chk_out("negative", 8'hFB, 8'h00, 8'h00);

        // Random gaps and backpressure; the model checks every value
        mready_mode = 2;
        for (int r = 0; r < 4; r++) begin
            got.delete(); e0 = ena_count;
            for (int i = 0; i < NE; i++) v[i] = 8'($urandom());
            stub_lat = $urandom_range(0, 8);
            send(v, 1, NE); wait_out(3);
            chki("random_ena_pulses", ena_count - e0, 1);
        end
        mready_mode = 1;

        // Done on the very last wait cycle still wins
        got.delete(); stub_lat = 62;
        v = '{8'd3,8'd0,8'd0, 8'd0,8'd3,8'd0, 8'd0,8'd0,8'd3, 8'd1,8'd2,8'd3};
        send(v, 0, NE); wait_out(3);
        chk_out("late_done", 8'd3, 8'd6, 8'd9);

        // Never done: timeout, no output
        got.delete(); stub_lat = -1;
        send(v, 0, NE); wait_timeout();
        repeat (5) @(posedge clk); #1;
        chki("timeout_no_output", got.size(), 0);

        // Done one cycle too late: timeout, stray done ignored
        stub_lat = 63;
        send(v, 0, NE); wait_timeout();
        repeat (5) @(posedge clk); #1;
        chki("stray_done_no_output", got.size(), 0);

        // Recovery run clears timeout_err
        got.delete(); stub_lat = 1;
        send(v, 0, NE); wait_out(3);
        chk_out("recover", 8'd3, 8'd6, 8'd9);
        chk1("timeout_cleared", timeout_err, 1'b0);

        // Reset mid-collect, then a fresh full load
        got.delete();
        v = '{8'd9,8'd9,8'd9, 8'd9,8'd9,8'd9, 8'd9,8'd9,8'd9, 8'd9,8'd9,8'd9};
        send(v, 0, 5);
        do_reset(2);
        v = '{8'd2,8'd2,8'd2, 8'd2,8'd2,8'd2, 8'd2,8'd2,8'd2, 8'd1,8'd1,8'd1};
        send(v, 0, NE); wait_out(3);
        chk_out("after_rst_collect", 8'd6, 8'd6, 8'd6);

        // Reset mid-drain discards the pending result
        got.delete(); mready_mode = 0;
        send(v, 0, NE);
        repeat (10) @(posedge clk); #1;
        chk1("stalled_valid", m_valid, 1'b1);
        do_reset(2);
        mready_mode = 1;
        repeat (3) @(posedge clk); #1;
        chki("drain_rst_no_output", got.size(), 0);
        got.delete();
        v = '{8'd1,8'd0,8'd0, 8'd0,8'd1,8'd0, 8'd0,8'd0,8'd1, 8'hFE,8'd4,8'h80};
        send(v, 0, NE); wait_out(3);
        chk_out("after_rst_drain", 8'hFE, 8'h04, 8'h80);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matvec_stream_frontend.md
# matvec_stream_frontend

Streaming front end for the matrix-vector multiplier. It takes matrix and vector elements one at a time on a valid/ready input stream and packs them into the multiplier's flat operand buses. It then starts the multiplier with a one-cycle enable, waits for its done pulse, and returns the result vector one element at a time on a valid/ready output stream. It sits between the lab's serial test/host interface and the multiplier core, and drives the multiplier's ena/done handshake from the initiator side.

## Interface
Parameters:
- N, 3, matrix dimension (N×N matrix, N-element vectors)
- WIDTH, 8, element width in bits, two's complement
- TIMEOUT, 64, maximum cycles to wait for mvm_done after start (must be ≥ N*N+4)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input element valid
- s_ready  out  1  frontend can accept an input element
- s_data  in  WIDTH  input element, signed
- m_valid  out  1  result element valid
- m_ready  in  1  downstream accepts the result element
- m_data  out  WIDTH  result element, signed
- m_last  out  1  marks result element N-1
- mvm_ena  out  1  one-cycle start pulse to the multiplier
- mvm_matrix_a  out  N*N*WIDTH  packed matrix
- mvm_vector_b  out  N*WIDTH  packed vector
- mvm_vector_c  in  N*WIDTH  packed result from the multiplier
- mvm_done  in  1  multiplier completion pulse
- busy  out  1  high in START, WAIT, DRAIN
- timeout_err  out  1  sticky; set on timeout, cleared by rst or the next START

## Operation
- States: COLLECT → START → WAIT → DRAIN → COLLECT. Reset state is COLLECT.
- COLLECT
  - s_ready = 1 (forced to 0 while rst is high).
  - Each handshake (s_valid & s_ready) stores s_data and increments the element index e, which runs 0..N*N+N-1.
  - e < N*N: the element goes to mvm_matrix_a[e*WIDTH +: WIDTH], in row-major order.
  - Otherwise the element goes to mvm_vector_b[(e-N*N)*WIDTH +: WIDTH].
  - The handshake on the last element moves the block to START and resets e to 0.
- START
  - mvm_ena = 1 for exactly this cycle; timeout_err is cleared.
  - Next state is WAIT.
- WAIT
  - The cycle counter increments every cycle.
  - mvm_done = 1: capture mvm_vector_c into the internal result register, go to DRAIN.
  - Otherwise, when the counter reaches TIMEOUT: set timeout_err, return to COLLECT with no output.
  - If mvm_done and the timeout occur in the same cycle, done wins.
- DRAIN
  - m_valid = 1 and m_data = result[j*WIDTH +: WIDTH], with j running 0..N-1; m_last = (j == N-1).
  - j advances only on m_valid & m_ready.
  - After the handshake on j = N-1, go to COLLECT.
  - m_data and m_last hold stable while m_valid = 1 and m_ready = 0.
- mvm_matrix_a and mvm_vector_b hold constant from START until the block re-enters COLLECT. The multiplier samples them one cycle after ena.
- mvm_done outside WAIT is ignored.
- No arithmetic is done here; data passes through bit-exact.

## Timing
- Reset values:
  - s_ready 0 during reset; m_valid 0, m_data 0, m_last 0, mvm_ena 0.
  - mvm_matrix_a 0, mvm_vector_b 0, busy 0, timeout_err 0.
  - Counters e, j and the wait counter are 0; state is COLLECT.
- s_ready is high from the first cycle after rst deasserts.
- Last input handshake at cycle t:
  - mvm_ena = 1 at t+1, and WAIT starts at t+2.
  - mvm_done seen at cycle d gives m_valid = 1 at d+1.
- Throughput: one input element per cycle, and one output element per cycle when m_ready is held high.
- Reset asserted in any state, including mid-collect or mid-drain: all partial data is discarded and the reset values apply on the next edge.

## Structure
- Package mvm_pkg holds:
  - the state enum (COLLECT, START, WAIT, DRAIN);
  - localparams for the total element count N*N+N and the counter widths ($clog2 of the element count, N and TIMEOUT+1).
- The multiplier and this frontend both import mvm_pkg.
- One sub-module is natural: matvec_result_serializer. It takes the captured N*WIDTH vector plus a load strobe and produces the m_valid/m_ready/m_data/m_last stream.

## Test plan
Benches use N=3, WIDTH=8, TIMEOUT=64 and the real multiplier unless stated.
- Identity matrix, vector {1,2,3}, m_ready held high → outputs 1, 2, 3; m_last only on 3; mvm_ena exactly one cycle.
- Matrix all 2, vector {1,1,1} → outputs 6, 6, 6. Repeat back-to-back with all 1s → 3, 3, 3; no stale data.
- Row 0 = {-1,0,0}, other rows 0, vector {5,7,9} → outputs 0xFB, 0x00, 0x00.
- Random s_valid gaps and m_ready toggling at 50% → values match the model; m_data stable under backpressure; no extra mvm_ena.
- Stub multiplier that never asserts done → timeout_err = 1 exactly 64 cycles into WAIT, s_ready = 1 next cycle, m_valid never asserts. The next run clears timeout_err at START.
- rst asserted after 5 input elements → outputs at reset values; a fresh 12-element load gives the correct result.
